// File: rtl/wb_ram_slave_pkg.sv
// Shared definitions for the Wishbone RAM slave: FSM state encoding,
// byte-lane constants, wait-counter width and the address range helper.
package wb_ram_slave_pkg;

  typedef enum logic [1:0] {
    WbSlvIdle = 2'd0,
    WbSlvWait = 2'd1,
    WbSlvResp = 2'd2
  } wb_slv_state_e;

  localparam logic [3:0] WbSelWord  = 4'b1111;
  localparam logic [3:0] WbSelNone  = 4'b0000;
  localparam int         WbCntWidth = 4;

  // True when any byte-address bit above the RAM's word index is set.
  function automatic logic adr_out_of_range(input logic [31:0] adr, input int addr_width);
    return (adr >> (addr_width + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// 2^ADDR_WIDTH x 32 synchronous RAM with per-byte write enables and a
// registered read port. Contents are never reset.
module wb_ram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read data register holds its value unless a read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  // Registered read port and byte-lane masked write.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B3 classic-cycle slave in front of a byte-writable word RAM.
// Programmable wait states delay ack/err; the RAM access happens on the
// edge that enters RESP. Optional upper-address range checking is enabled
// with the WB_RAM_RANGE_CHECK_EN macro (err response instead of ack).
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam logic [WbCntWidth-1:0] CntLoad =
    (WAIT_STATES > 0) ? WbCntWidth'(WAIT_STATES - 1) : '0;

  // Handshake: a request is taken in IDLE when wb_cyc_i & wb_stb_i are both
  // high at a clk edge; exactly one ack or err pulse follows after
  // WAIT_STATES+1 cycles unless wb_cyc_i drops during WAIT (silent abort).

  wb_slv_state_e           state_q, state_d;
  logic [WbCntWidth-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic [3:0]              sel_q, sel_d;
  logic [31:0]             dat_q, dat_d;
  logic                    oor_q, oor_d;
  logic                    ack_q, ack_d;
  logic                    rd_ack_q, rd_ack_d;

  logic                    req;
  logic                    new_oor;
  logic                    enter_resp;
  logic [ADDR_WIDTH-1:0]   eff_idx;
  logic                    eff_we;
  logic [3:0]              eff_sel;
  logic [31:0]             eff_dat;
  logic                    eff_oor;
  logic                    ram_we;
  logic                    ram_re;
  logic [31:0]             ram_rdata;

`ifdef WB_RAM_RANGE_CHECK_EN
  logic err_q, err_d;
  logic unused_adr;
  assign new_oor    = adr_out_of_range(wb_adr_i, ADDR_WIDTH);
  assign unused_adr = ^wb_adr_i[1:0];
`else
  logic unused_adr;
  assign new_oor    = 1'b0;
  assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};
`endif

  assign req = wb_cyc_i & wb_stb_i;

  // Next state, request latching and RAM access control. With zero wait
  // states RESP is entered on the accepting edge, so the live bus values
  // feed the RAM; otherwise the latched copy does.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    oor_d      = oor_q;
    enter_resp = 1'b0;

    if (state_q == WbSlvIdle) begin
      eff_idx = wb_adr_i[ADDR_WIDTH+1:2];
      eff_we  = wb_we_i;
      eff_sel = wb_sel_i;
      eff_dat = wb_dat_i;
      eff_oor = new_oor;
    end else begin
      eff_idx = idx_q;
      eff_we  = we_q;
      eff_sel = sel_q;
      eff_dat = dat_q;
      eff_oor = oor_q;
    end

    case (state_q)
      WbSlvIdle: begin
        if (req) begin
          idx_d = wb_adr_i[ADDR_WIDTH+1:2];
          we_d  = wb_we_i;
          sel_d = wb_sel_i;
          dat_d = wb_dat_i;
          oor_d = new_oor;
          if (WAIT_STATES == 0) begin
            state_d    = WbSlvResp;
            enter_resp = 1'b1;
          end else begin
            state_d = WbSlvWait;
            cnt_d   = CntLoad;
          end
        end
      end
      WbSlvWait: begin
        if (!wb_cyc_i) begin
          state_d = WbSlvIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d    = WbSlvResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WbSlvResp: begin
        state_d = WbSlvIdle;
      end
      default: begin
        state_d = WbSlvIdle;
      end
    endcase

    ack_d    = enter_resp & ~eff_oor;
    rd_ack_d = enter_resp & ~eff_oor & ~eff_we;
    ram_we   = enter_resp & eff_we & ~eff_oor & ~rst & (eff_sel != WbSelNone);
    ram_re   = rd_ack_d & ~rst;
  end

`ifdef WB_RAM_RANGE_CHECK_EN
  // Error pulse for an out-of-range latched address.
  always_comb begin
    err_d = enter_resp & eff_oor;
  end

  // Error response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign wb_err_o = err_q;
`else
  assign wb_err_o = 1'b0;
`endif

  // FSM, wait counter, latched request and response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WbSlvIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      oor_q    <= 1'b0;
      ack_q    <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      oor_q    <= oor_d;
      ack_q    <= ack_d;
      rd_ack_q <= rd_ack_d;
    end
  end

  wb_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .be_i   (eff_sel),
    .re_i   (ram_re),
    .addr_i (eff_idx),
    .wdata_i(eff_dat),
    .rdata_o(ram_rdata)
  );

  assign wb_ack_o = ack_q;
  // Read data is only presented during a read ack; zero otherwise.
  assign wb_dat_o = rd_ack_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances with 1, 3 and 0 wait states,
// directed scenarios followed by random accesses against a word-array model.
module tb_wb_ram_slave;
  import wb_ram_slave_pkg::*;

  localparam int AW = 10;
`ifdef WB_RAM_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rdat [3];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [3][1024];

  // clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    wb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .wb_adr_i(adr),
      .wb_dat_i(wdat),
      .wb_dat_o(rdat[g]),
      .wb_we_i (we),
      .wb_sel_i(sel),
      .wb_stb_i(stb[g]),
      .wb_cyc_i(cyc[g]),
      .wb_ack_o(ack[g]),
      .wb_err_o(err[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k, checked against the model.
  task automatic access(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit drop_stb, output logic [31:0] got);
    int          idx;
    bit          oor;
    int          lat;
    bit          done;
    logic [31:0] exp_rd;
    idx    = int'(a[11:2]);
    oor    = RangeEn && ((a >> 12) != 32'd0);
    exp_rd = oor ? 32'd0 : mdl[k][idx];
    adr = a; wdat = d; we = w; sel = s;
    cyc[k] = 1'b1; stb[k] = 1'b1;
    lat = 0; done = 1'b0; got = '0;
    for (int n = 1; n <= 40 && !done; n++) begin
      tick();
      if (drop_stb && n == 1) stb[k] = 1'b0;
      if (ack[k] || err[k]) begin
        lat  = n;
        done = 1'b1;
        got  = rdat[k];
        check("ack_err_excl", 32'(ack[k] & err[k]), 32'd0);
        check("resp_kind", 32'({ack[k], err[k]}), oor ? 32'd1 : 32'd2);
        if (!w) check("rd_data", rdat[k], exp_rd);
      end
    end
    check("latency", lat, ws_of(k) + 1);
    cyc[k] = 1'b0; stb[k] = 1'b0;
    tick();
    check("resp_pulse", 32'({ack[k], err[k]}), 32'd0);
    check("dat_idle", rdat[k], 32'd0);
    if (w && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] prior;
    bit          seen;

    rst = 1'b1; adr = '0; wdat = '0; we = 1'b0; sel = WbSelNone;
    cyc = '0; stb = '0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_ack", 32'(ack[k]), 32'd0);
      check("rst_err", 32'(err[k]), 32'd0);
      check("rst_dat", rdat[k], 32'd0);
    end
    check("rst_state", 32'(g_dut[1].u_dut.state_q), 32'(WbSlvIdle));
    rst = 1'b0;
    tick();

    // preload words 0..15 on every instance
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        access(k, 1'b1, 32'(i * 4), $urandom, WbSelWord, 1'b0, got);
      end
    end

    // full-word write then read, then single-lane update
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, WbSelWord, 1'b0, got);
    access(0, 1'b0, 32'h10, 32'h0, WbSelWord, 1'b0, got);
    check("tp_word", got, 32'hDEADBEEF);
    access(0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 1'b0, got);
    access(0, 1'b0, 32'h10, 32'h0, WbSelNone, 1'b0, got);
    check("tp_lane", got, 32'hDEAABEEF);

    // abort: cyc dropped in cycle 2 of a 3-wait-state write
    prior = mdl[1][8];
    adr = 32'h20; wdat = 32'h12345678; we = 1'b1; sel = WbSelWord;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    seen = 1'b0;
    tick(); seen |= ack[1] | err[1];
    tick(); seen |= ack[1] | err[1];
    cyc[1] = 1'b0; stb[1] = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick(); seen |= ack[1] | err[1];
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    access(1, 1'b0, 32'h20, 32'h0, WbSelWord, 1'b0, got);
    check("abort_word", got, prior);

    // reset in cycle 2 of a 3-wait-state write
    prior = mdl[1][9];
    adr = 32'h24; wdat = 32'hCAFEF00D; we = 1'b1; sel = WbSelWord;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_mid_ack", 32'({ack[1], err[1]}), 32'd0);
    check("rst_mid_state", 32'(g_dut[1].u_dut.state_q), 32'(WbSlvIdle));
    check("rst_mid_dat", rdat[1], 32'd0);
    rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    access(1, 1'b0, 32'h24, 32'h0, WbSelWord, 1'b0, got);
    check("rst_mid_word", got, prior);

    // stb dropped while cyc stays high during WAIT
    access(1, 1'b1, 32'h28, 32'hA5A55A5A, WbSelWord, 1'b1, got);
    access(1, 1'b0, 32'h28, 32'h0, WbSelWord, 1'b0, got);
    check("stb_drop_word", got, 32'hA5A55A5A);

    // zero wait states: held request, reads accepted every 2 cycles
    we = 1'b0; sel = WbSelWord; cyc[2] = 1'b1; stb[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      adr = 32'(j * 4);
      tick();
      check("b2b_ack", 32'(ack[2]), 32'd1);
      check("b2b_data", rdat[2], mdl[2][j]);
      tick();
      check("b2b_gap", 32'(ack[2]), 32'd0);
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    tick();

    // upper address bits: err with range check, alias of word 0 without
    access(0, 1'b0, 32'h00001000, 32'h0, WbSelWord, 1'b0, got);
    access(0, 1'b1, 32'h00001000, 32'h55555555, WbSelWord, 1'b0, got);
    access(0, 1'b0, 32'h00000000, 32'h0, WbSelWord, 1'b0, got);
    if (RangeEn) check("oor_no_write", got, mdl[0][0]);
    else         check("alias_write", got, 32'h55555555);

    // random traffic
    for (int t = 0; t < 90; t++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      a = {20'd0, 6'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom_range(1, 32'hFFFFF));
      access(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             (k == 1) && ($urandom_range(0, 1) == 1), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
Wishbone B3 classic-cycle slave that backs a word-organised, byte-lane-writable on-chip RAM. It is the responder for the openmips instruction-side and data-side Wishbone masters, and sits behind the bus interconnect or directly on one master port. Access latency is set by a programmable number of wait states. Out-of-range addresses are reported through an error response.

Parameters:
- ADDR_WIDTH, 10: number of word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1: extra cycles inserted before ack/err; legal range 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- wb_adr_i  in  32  byte address; bits [1:0] ignored
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data; valid only while wb_ack_o=1
- wb_we_i  in  1  1 = write, 0 = read
- wb_sel_i  in  4  byte lanes: sel[3]=dat[31:24], sel[2]=dat[23:16], sel[1]=dat[15:8], sel[0]=dat[7:0]
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle valid
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination (only with the optional feature)

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset values: state=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
- Reset does not clear RAM contents.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clk edge with wb_cyc_i & wb_stb_i = 1, latch adr, we, sel and dat_i.
  - Go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1); otherwise go to RESP.
- WAIT:
  - If wb_cyc_i=0, abort: go to IDLE with no RAM write and no response.
  - Else if counter=0, go to RESP; else decrement the counter.
- Entering RESP (the same edge that raises ack):
  - Write: RAM word[adr[ADDR_WIDTH+1:2]] is updated only on lanes with sel=1.
  - Read: the full word is registered into wb_dat_o.
  - sel=0000 performs no write; a read with sel=0000 still returns the full word.
- RESP:
  - wb_ack_o (or wb_err_o) is high for exactly one cycle, then the FSM returns to IDLE unconditionally.
  - wb_dat_o returns to 0 on the next edge.
- Latency: request present in cycle 0 → response in cycle WAIT_STATES+1.
  - Minimum spacing between accepted requests is WAIT_STATES+2 cycles, because IDLE is mandatory after RESP.
- wb_stb_i dropping while wb_cyc_i stays high during WAIT is ignored; the transaction completes on the latched request.
- wb_ack_o and wb_err_o are never high simultaneously and are never high outside RESP.
- Reset asserted in any state: the next edge goes to IDLE, any pending write is dropped, and all outputs take their reset values.
- Address wrap: the word index is taken modulo 2^ADDR_WIDTH when range checking is compiled out.

Optional Feature:
- Macro WB_RAM_RANGE_CHECK_EN.
- When defined:
  - If any latched wb_adr_i bit above ADDR_WIDTH+1 is nonzero, RESP asserts wb_err_o instead of wb_ack_o.
  - No RAM write occurs and wb_dat_o stays 0.
- When undefined:
  - wb_err_o is tied to 0.
  - Upper address bits are ignored (aliasing) and every request is acked.

Decomposition:
- The shared defines file holds:
  - FSM state encodings (WbSlvIdle, WbSlvWait, WbSlvResp).
  - Byte-lane constants (WbSelWord=4'b1111, WbSelNone=4'b0000).
  - The wait-counter width constant (4).
- Sub-module wb_ram_array contains the 2^ADDR_WIDTH x 32 synchronous RAM with a per-byte write enable and a registered read port.
- The FSM, wait counter and range check live in wb_ram_slave.

Test Plan:
- WAIT_STATES=1: write 0xDEADBEEF to 0x00000010 with sel=1111, then read 0x10 → each ack arrives 2 cycles after stb; the read returns 0xDEADBEEF.
- Byte lanes: after the word is 0xDEADBEEF, write 0x00AA0000 with sel=0100 to 0x10, then read → 0xDEAAEEF... lanes 3, 1 and 0 are preserved, giving 0xDEAABEEF.
- Abort: WAIT_STATES=3, issue a write of 0x12345678 to 0x20 and drop cyc in cycle 2 → no ack; a subsequent read of 0x20 returns the prior value.
- Reset mid-WAIT: WAIT_STATES=3, assert rst in cycle 2 of a write → no ack, FSM is in IDLE, the target word is unchanged, and the next access completes normally.
- WAIT_STATES=0 back-to-back reads of 0x0, 0x4, 0x8 → ack in cycle 1 of each; requests are accepted every 2 cycles; data matches the preloaded values.
- With WB_RAM_RANGE_CHECK_EN and ADDR_WIDTH=10: access 0x00001000 → one-cycle wb_err_o, no ack, wb_dat_o=0. Without the macro the same access aliases word 0 and is acked.
